// File: rtl/inport_credit_unit_pkg.sv
// Link-level constants shared by the credit-return transmitter and receiver.
// Idle levels describe the differential pair immediately after downstream reset.
package inport_credit_unit_pkg;

    localparam logic LINK_IDLE_P          = 1'b1;
    localparam logic LINK_IDLE_N          = 1'b0;
    localparam int   DEFAULT_BUFFER_DEPTH = 4;
    localparam int   DEFAULT_GLITCH_LIMIT = 4;

    // Width of a counter that must hold every value in 0..max_value.
    function automatic int count_width(input int max_value);
        return (max_value < 1) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage

// File: rtl/inport_credit_unit_sync_2ff.sv
// Single-bit two-flop synchroniser with a configurable reset level so the
// output comes out of reset already at the link idle value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= RESET_VAL;
            sync_r <= RESET_VAL;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/inport_credit_unit.sv
// Upstream credit tracker: decodes the two-phase differential credit-return
// pair, counts credits against launched flits and flags protocol violations.
module inport_credit_unit
    import inport_credit_unit_pkg::*;
#(
    parameter int BUFFER_DEPTH = DEFAULT_BUFFER_DEPTH,
    parameter int GLITCH_LIMIT = DEFAULT_GLITCH_LIMIT
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                diff_pair_p,
    input  logic                                diff_pair_n,
    input  logic                                flit_sent,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]   credit_count,
    output logic                                credit_available,
    output logic                                protocol_error
);

    localparam int CW = $clog2(BUFFER_DEPTH + 1);
    localparam int GW = count_width(GLITCH_LIMIT);
    localparam logic [CW-1:0] MAX_COUNT   = CW'(BUFFER_DEPTH);
    localparam logic [GW-1:0] GLITCH_MAX  = GW'(GLITCH_LIMIT);

    logic          sp_s;
    logic          sn_s;
    logic          valid_s;
    logic          credit_ret_s;
    logic          last_p_r;
    logic          last_p_next_s;
    logic [GW-1:0] glitch_cnt_r;
    logic [GW-1:0] glitch_next_s;
    logic          glitch_hit_s;
    logic [CW-1:0] credit_count_r;
    logic [CW-1:0] count_next_s;
    logic          overflow_s;
    logic          underflow_s;
    logic          credit_available_r;
    logic          protocol_error_r;
    logic          error_next_s;

    sync_2ff #(.RESET_VAL(LINK_IDLE_P)) u_sync_p (
        .clk   (clk),
        .reset (reset),
        .d     (diff_pair_p),
        .q     (sp_s)
    );

    sync_2ff #(.RESET_VAL(LINK_IDLE_N)) u_sync_n (
        .clk   (clk),
        .reset (reset),
        .d     (diff_pair_n),
        .q     (sn_s)
    );

    // Pair validity, toggle detection and glitch accounting.
    always_comb begin
        valid_s       = (sp_s != sn_s);
        credit_ret_s  = valid_s && (sp_s != last_p_r);
        last_p_next_s = credit_ret_s ? sp_s : last_p_r;

        if (valid_s) begin
            glitch_next_s = {GW{1'b0}};
        end else if (glitch_cnt_r < GLITCH_MAX) begin
            glitch_next_s = glitch_cnt_r + GW'(1);
        end else begin
            glitch_next_s = glitch_cnt_r;
        end
        glitch_hit_s = (glitch_next_s == GLITCH_MAX);
    end

    // Credit counter next state; a simultaneous return and launch cancel out.
    always_comb begin
        count_next_s = credit_count_r;
        overflow_s   = 1'b0;
        underflow_s  = 1'b0;
        case ({credit_ret_s, flit_sent})
            2'b10: begin
                if (credit_count_r == MAX_COUNT) begin
                    overflow_s = 1'b1;
                end else begin
                    count_next_s = credit_count_r + CW'(1);
                end
            end
            2'b01: begin
                if (credit_count_r == {CW{1'b0}}) begin
                    underflow_s = 1'b1;
                end else begin
                    count_next_s = credit_count_r - CW'(1);
                end
            end
            default: begin
                count_next_s = credit_count_r;
            end
        endcase
        error_next_s = protocol_error_r | glitch_hit_s | overflow_s | underflow_s;
    end

    // State registers; availability is registered from the next count so it
    // tracks credit_count with no extra cycle of latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_p_r           <= LINK_IDLE_P;
            glitch_cnt_r       <= {GW{1'b0}};
            credit_count_r     <= MAX_COUNT;
            credit_available_r <= (MAX_COUNT != {CW{1'b0}});
            protocol_error_r   <= 1'b0;
        end else begin
            last_p_r           <= last_p_next_s;
            glitch_cnt_r       <= glitch_next_s;
            credit_count_r     <= count_next_s;
            credit_available_r <= (count_next_s != {CW{1'b0}});
            protocol_error_r   <= error_next_s;
        end
    end

    assign credit_count     = credit_count_r;
    assign credit_available = credit_available_r;
    assign protocol_error   = protocol_error_r;

endmodule

// File: doc/inport_credit_unit.md
Name: inport_credit_unit

Overview:
Upstream-side credit tracker for one router link. It consumes the two-phase differential credit-return pair driven by the downstream port's protocol handler. Each toggle of that pair means one downstream buffer slot has been freed. The block synchronises and validates the pair, counts returned credits against flits sent, and tells the local arbiter whether a flit may be launched.

Parameters:
BUFFER_DEPTH, 4, downstream input buffer depth in flits; initial and maximum credit count.
GLITCH_LIMIT, 4, consecutive cycles the synchronised pair may sit non-complementary (p==n) before a protocol error is flagged.

Ports:
clk  input  1  single system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
diff_pair_p  input  1  credit-return line, true leg; asynchronous to local logic; idle level after downstream reset is 1.
diff_pair_n  input  1  credit-return line, complement leg; idle level is 0.
flit_sent  input  1  one-cycle pulse from the arbiter: one flit was launched, consume one credit.
credit_count  output  $clog2(BUFFER_DEPTH+1)  credits currently held.
credit_available  output  1  high when credit_count != 0.
protocol_error  output  1  sticky error flag; cleared only by reset.

Behaviour:
- Reset (synchronous, active-high):
  - sync stages for p/n load 1/0, matching the link idle level.
  - last_p = 1, glitch_cnt = 0.
  - credit_count = BUFFER_DEPTH, credit_available = 1, protocol_error = 0.
  - A reset asserted mid-operation discards in-flight toggles and returns to exactly this state.
- Synchronisation: each leg passes through a 2-flop synchroniser, giving sp/sn. The synchroniser has no combinational path to the outputs.
- Pair validity:
  - valid = (sp != sn).
  - While invalid, glitch_cnt increments, saturating at GLITCH_LIMIT.
  - When glitch_cnt reaches GLITCH_LIMIT, protocol_error sets.
  - On valid, glitch_cnt clears.
- Toggle detect:
  - credit_ret = valid && (sp != last_p); on credit_ret, last_p <= sp.
  - No credit is counted while the pair is invalid. Skewed leg arrival (p changes, n follows within fewer than GLITCH_LIMIT cycles) therefore yields exactly one credit, counted when the pair becomes valid again.
- Latency: a pair change present at rising edge k is captured at edge k, reaches sp/sn at edge k+1, and updates credit_count at edge k+2 (credit_ret is combinational on sp/sn).
- Counter update, registered:
  - credit_ret && flit_sent: count unchanged.
  - credit_ret only: if count == BUFFER_DEPTH, hold count (saturate) and set protocol_error; else count+1.
  - flit_sent only: if count == 0, hold count at 0 and set protocol_error; else count-1.
  - neither: hold.
- credit_available is decoded combinationally from the credit_count register (no extra latency). When count goes 1→0 on a flit_sent, credit_available is low in the next cycle.
- protocol_error stays high once set. Counting continues normally after an error.

Decomposition:
- Shared header file: localparams for link idle levels (LINK_IDLE_P=1, LINK_IDLE_N=0) and default BUFFER_DEPTH. The downstream protocol handler and this block both include it.
- One sub-module: sync_2ff (1-bit two-flop synchroniser, reset value parameter). Instantiated twice.
- Remaining logic (validity, toggle detect, glitch counter, credit counter) stays flat in inport_credit_unit.

Test Plan:
1. Hold reset 2 cycles, pair idle p=1/n=0 -> credit_count=4, credit_available=1, protocol_error=0; the same values are read on the first cycle after reset deasserts.
2. Four flit_sent pulses from reset -> count 3,2,1,0, credit_available=0 after the fourth. A fifth flit_sent -> count stays 0, protocol_error=1.
3. From count=2, flip pair to p=0/n=1 just before edge k -> count=3 after edge k+2 and not before. A second flip back to p=1/n=0 -> count=4.
4. At count=2, pair toggle whose credit_ret cycle coincides with a flit_sent pulse -> count remains 2, no error.
5. Skew: p goes 0 at edge k, n goes 1 two cycles later -> exactly one credit, no error. Then force p=n=0 for 4 cycles -> protocol_error=1 and no credit counted during the invalid window.
6. At count=4, toggle pair -> count stays 4, protocol_error=1. Assert reset mid-stream while a toggle is in the synchroniser -> count=4, error=0, and no credit is counted from the discarded toggle.
